lcd_write_scheduler: RTL and testbench
======================================

Name: lcd_write_scheduler

Overview:
Shared controller for the 16x2 character LCD (HD44780-style, write-only, 8-bit bus).
- After reset, runs the power-up wait and the init command sequence on its own.
- Then arbitrates byte-write requests from two requesters (result writer, key-echo writer) round-robin.
- Drives lcd_e/lcd_rs/lcd_rw/lcd_data with tick-based setup/pulse/hold timing.
- Sits between the calculator display logic and the LCD pins.

Parameters:
- CLK_DIV, 5: clk cycles per timing tick (range 2..65535).
- POWERUP_TICKS, 70: ticks waited after reset before the first init command.
- E_TICKS, 1: ticks lcd_e is held high per transfer.
- WAIT_TICKS, 2: ticks lcd_e is held low after a normal transfer.
- LONG_WAIT_TICKS, 200: hold ticks after the clear (0x01) or home (0x02/0x03) commands, rs=0.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: reset, synchronous, active-high.
- req, in, 2: per-requester write request; held until the matching gnt bit.
- req_rs, in, 2: per-requester rs (0 = command, 1 = character).
- req_data, in, 16: byte for requester i at [8i+7:8i].
- gnt, out, 2: one-clk acceptance pulse, at most one bit set.
- busy, out, 1: high whenever the FSM is not in IDLE.
- init_done, out, 1: high once the init sequence has completed; sticky until rst.
- lcd_e, out, 1: LCD enable strobe.
- lcd_rs, out, 1: LCD register select.
- lcd_rw, out, 1: LCD read/write; constant 0.
- lcd_data, out, 8: LCD data bus.

Behaviour:
- Reset values: lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00, gnt=0, busy=1, init_done=0, rr pointer=1.
- Clocking: all logic on posedge clk. rst is synchronous, active-high.
- Reset mid-transfer aborts the transfer: outputs go to reset values on the next edge and the full init sequence is replayed.
- Tick generation:
  - Divider counts 0..CLK_DIV-1; tick is a one-clk pulse when the count equals CLK_DIV-1.
  - The divider restarts at 0 on rst.
  - All FSM phase counters advance only on tick.
- FSM states: POWERUP, INIT, IDLE, SETUP, PULSE, HOLD.
- POWERUP → INIT after POWERUP_TICKS ticks; lcd_e stays 0.
- INIT loads init command k into the transfer latch (rs=0), then → SETUP. Commands, in order:
  - k=0: 0x38 (8-bit, 2 lines)
  - k=1: 0x0C (display on, cursor off)
  - k=2: 0x06 (entry increment)
  - k=3: 0x01 (clear)
- After the HOLD of k=3, init_done is set and the FSM → IDLE.
- SETUP (1 tick): lcd_rs/lcd_data driven from the latch, lcd_e=0.
- PULSE (E_TICKS ticks): lcd_e=1; rs/data unchanged.
- HOLD: lcd_e=0; lasts LONG_WAIT_TICKS for rs=0 with data in {0x01,0x02,0x03}, otherwise WAIT_TICKS. Exit to INIT (next k) if init is incomplete, else to IDLE.
- lcd_rs/lcd_data keep their last value through HOLD and IDLE.
- IDLE arbitration, evaluated every clk, not only on tick:
  - If any req bit is set, grant one requester.
  - Only one set: grant it.
  - Both set: grant the requester not equal to the rr pointer (rr=1 after reset, so requester 0 wins the first tie).
  - On grant: latch that requester's rs/data, set gnt[i]=1 for the next clk, set rr=i, and go to SETUP.
  - The transition happens on the same edge as the grant; the divider is not resynchronised, so SETUP lasts until the next tick (at most 1 tick).
- Requests arriving before init_done are not granted; they stay pending.
- Requesters must change or drop req in the cycle after seeing gnt. No double grant is possible, since IDLE is re-entered at least 3 ticks later.
- Minimum transfer length is 1 + E_TICKS + WAIT_TICKS ticks.

Optional Feature:
- Macro: LCD_AUTO_LINE_EN.
- When defined: the block tracks cursor line (0/1) and column (0..16).
  - Each granted rs=1 write increments the column.
  - rs=0 data 0x80..0x8F sets line 0 with col=data[3:0].
  - rs=0 data 0xC0..0xCF sets line 1 with col=data[3:0].
  - 0x01, 0x02 and 0x03 set line 0, col 0.
  - When a rs=1 request is granted with col==16, the block first inserts an internal command transfer (0xC0 if on line 0, 0x80 if on line 1), then sends the character; tracking becomes the new line, col=1.
  - gnt still pulses once, at acceptance.
- When not defined: no tracking, no inserted commands.

Decomposition:
- Package lcd_pkg holds:
  - the FSM state enum;
  - LCD command constants (CMD_FUNC_SET=0x38, CMD_DISP_ON=0x0C, CMD_ENTRY=0x06, CMD_CLEAR=0x01, CMD_HOME=0x02, CMD_LINE1=0x80, CMD_LINE2=0xC0);
  - the init ROM array.
- Sub-module lcd_tick_gen: parameterised by CLK_DIV; ports clk, rst, tick.

Test Plan:
- Reset with defaults (CLK_DIV=5) → first lcd_e rise at clk 70*5+5=355 after rst release, with lcd_data=0x38, rs=0. Each of the 4 init commands gives exactly one lcd_e pulse 5 clk wide. init_done rises only after the clear's 200-tick hold.
- req=01 before init_done → gnt stays 0; after init_done → gnt=01 for one clk; the next lcd_e pulse carries rs=1, data=0x48.
- req=11 held, data 0x41/0x42 → grants alternate 01,10,01,… with bytes 0x41,0x42,0x41 on the bus; never both gnt bits set.
- Requester 1 sends rs=0, 0x01 → the following HOLD lasts 200 ticks (1000 clk) before busy falls; rs=0, 0xC0 holds 2 ticks.
- rst asserted during PULSE of a character → on the next edge lcd_e=0, busy=1, init_done=0; the full init sequence repeats.
- With LCD_AUTO_LINE_EN, 17 rs=1 writes after clear → an extra rs=0, 0xC0 transfer appears before the 17th character; 17 gnt pulses total.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and LCD command constants for the LCD write scheduler.
package lcd_pkg;

   typedef enum logic [2:0] {
      StPowerup = 3'd0,
      StInit    = 3'd1,
      StIdle    = 3'd2,
      StSetup   = 3'd3,
      StPulse   = 3'd4,
      StHold    = 3'd5
   } state_e;

   localparam logic [7:0] CMD_FUNC_SET = 8'h38;
   localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
   localparam logic [7:0] CMD_ENTRY    = 8'h06;
   localparam logic [7:0] CMD_CLEAR    = 8'h01;
   localparam logic [7:0] CMD_HOME     = 8'h02;
   localparam logic [7:0] CMD_LINE1    = 8'h80;
   localparam logic [7:0] CMD_LINE2    = 8'hC0;

   localparam int unsigned INIT_LEN = 4;

   // Entry k sits at INIT_ROM[k].
   localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {CMD_CLEAR, CMD_ENTRY, CMD_DISP_ON, CMD_FUNC_SET};

   // Clear and home need the long execution wait.
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
      return !rs && (data == CMD_CLEAR || data == CMD_HOME || data == 8'h03);
   endfunction

endpackage

// File: rtl/lcd_tick_gen.sv
// Free-running divider giving a one-clk tick every CLK_DIV clocks.
module lcd_tick_gen #(
   parameter int unsigned CLK_DIV = 5
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   logic [15:0] cnt;

   assign tick = (cnt == 16'(CLK_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= 16'd0;
      end else if (tick) begin
         cnt <= 16'd0;
      end else begin
         cnt <= cnt + 16'd1;
      end
   end

endmodule

// File: rtl/lcd_write_scheduler.sv
// HD44780 write scheduler: power-up init, round-robin arbitration of two writers.
// Optional LCD_AUTO_LINE_EN: cursor tracking with automatic wrap to the other line.
module lcd_write_scheduler
   import lcd_pkg::*;
#(
   parameter int unsigned CLK_DIV         = 5,
   parameter int unsigned POWERUP_TICKS   = 70,
   parameter int unsigned E_TICKS         = 1,
   parameter int unsigned WAIT_TICKS      = 2,
   parameter int unsigned LONG_WAIT_TICKS = 200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req,
   input  logic [1:0]  req_rs,
   input  logic [15:0] req_data,
   output logic [1:0]  gnt,
   output logic        busy,
   output logic        init_done,
   output logic        lcd_e,
   output logic        lcd_rs,
   output logic        lcd_rw,
   output logic [7:0]  lcd_data
);

   localparam logic [15:0] PowerupLast = 16'(POWERUP_TICKS - 1);
   localparam logic [15:0] ELast       = 16'(E_TICKS - 1);
   localparam logic [15:0] WaitLast    = 16'(WAIT_TICKS - 1);
   localparam logic [15:0] LongLast    = 16'(LONG_WAIT_TICKS - 1);

   logic tick;

   lcd_tick_gen #(
      .CLK_DIV(CLK_DIV)
   ) u_tick_gen (
      .clk (clk),
      .rst (rst),
      .tick(tick)
   );

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [1:0]  k_q, k_d;
   logic        lat_rs_q, lat_rs_d;
   logic [7:0]  lat_data_q, lat_data_d;
   logic [1:0]  gnt_q, gnt_d;
   logic        rr_q, rr_d;
   logic        init_done_q, init_done_d;
   logic        lcd_e_q, lcd_e_d;
   logic        lcd_rs_q, lcd_rs_d;
   logic [7:0]  lcd_data_q, lcd_data_d;

   logic        gr_idx;
   logic        gr_rs;
   logic [7:0]  gr_data;
   logic [15:0] hold_last;

`ifdef LCD_AUTO_LINE_EN
   logic        line_q, line_d;
   logic [4:0]  col_q, col_d;
   logic        ins_pend_q, ins_pend_d;
   logic [7:0]  ins_data_q, ins_data_d;
`endif

   // Tie goes to the requester that was not served last.
   assign gr_idx    = (req == 2'b11) ? ~rr_q : req[1];
   assign gr_rs     = gr_idx ? req_rs[1] : req_rs[0];
   assign gr_data   = gr_idx ? req_data[15:8] : req_data[7:0];
   assign hold_last = is_long_cmd(lat_rs_q, lat_data_q) ? LongLast : WaitLast;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      k_d         = k_q;
      lat_rs_d    = lat_rs_q;
      lat_data_d  = lat_data_q;
      gnt_d       = 2'b00;
      rr_d        = rr_q;
      init_done_d = init_done_q;
      lcd_rs_d    = lcd_rs_q;
      lcd_data_d  = lcd_data_q;
`ifdef LCD_AUTO_LINE_EN
      line_d      = line_q;
      col_d       = col_q;
      ins_pend_d  = ins_pend_q;
      ins_data_d  = ins_data_q;
`endif
      unique case (state_q)
         StPowerup: begin
            if (tick) begin
               if (cnt_q == PowerupLast) begin
                  state_d = StInit;
                  cnt_d   = 16'd0;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
         end
         StInit: begin
            lat_rs_d   = 1'b0;
            lat_data_d = INIT_ROM[k_q];
            cnt_d      = 16'd0;
            state_d    = StSetup;
         end
         StIdle: begin
            if (req != 2'b00) begin
               lat_rs_d       = gr_rs;
               lat_data_d     = gr_data;
               gnt_d[gr_idx]  = 1'b1;
               rr_d           = gr_idx;
               cnt_d          = 16'd0;
               state_d        = StSetup;
`ifdef LCD_AUTO_LINE_EN
               if (gr_rs) begin
                  if (col_q == 5'd16) begin
                     ins_pend_d = 1'b1;
                     ins_data_d = gr_data;
                     lat_rs_d   = 1'b0;
                     lat_data_d = line_q ? CMD_LINE1 : CMD_LINE2;
                     line_d     = ~line_q;
                     col_d      = 5'd1;
                  end else begin
                     col_d = col_q + 5'd1;
                  end
               end else if (gr_data[7:4] == 4'h8) begin
                  line_d = 1'b0;
                  col_d  = {1'b0, gr_data[3:0]};
               end else if (gr_data[7:4] == 4'hC) begin
                  line_d = 1'b1;
                  col_d  = {1'b0, gr_data[3:0]};
               end else if (is_long_cmd(1'b0, gr_data)) begin
                  line_d = 1'b0;
                  col_d  = 5'd0;
               end
`endif
            end
         end
         StSetup: begin
            lcd_rs_d   = lat_rs_q;
            lcd_data_d = lat_data_q;
            if (tick) begin
               cnt_d   = 16'd0;
               state_d = StPulse;
            end
         end
         StPulse: begin
            if (tick) begin
               if (cnt_q == ELast) begin
                  cnt_d   = 16'd0;
                  state_d = StHold;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
         end
         StHold: begin
            if (tick) begin
               if (cnt_q == hold_last) begin
                  cnt_d = 16'd0;
                  if (!init_done_q) begin
                     if (k_q == 2'(INIT_LEN - 1)) begin
                        init_done_d = 1'b1;
                        state_d     = StIdle;
                     end else begin
                        k_d     = k_q + 2'd1;
                        state_d = StInit;
                     end
                  end else begin
                     state_d = StIdle;
                  end
`ifdef LCD_AUTO_LINE_EN
                  // Character that was held back behind the inserted line command.
                  if (ins_pend_q) begin
                     ins_pend_d = 1'b0;
                     lat_rs_d   = 1'b1;
                     lat_data_d = ins_data_q;
                     state_d    = StSetup;
                  end
`endif
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
         end
         default: state_d = StPowerup;
      endcase
      lcd_e_d = (state_d == StPulse);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StPowerup;
         cnt_q       <= 16'd0;
         k_q         <= 2'd0;
         lat_rs_q    <= 1'b0;
         lat_data_q  <= 8'h00;
         gnt_q       <= 2'b00;
         rr_q        <= 1'b1;
         init_done_q <= 1'b0;
         lcd_e_q     <= 1'b0;
         lcd_rs_q    <= 1'b0;
         lcd_data_q  <= 8'h00;
`ifdef LCD_AUTO_LINE_EN
         line_q      <= 1'b0;
         col_q       <= 5'd0;
         ins_pend_q  <= 1'b0;
         ins_data_q  <= 8'h00;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         k_q         <= k_d;
         lat_rs_q    <= lat_rs_d;
         lat_data_q  <= lat_data_d;
         gnt_q       <= gnt_d;
         rr_q        <= rr_d;
         init_done_q <= init_done_d;
         lcd_e_q     <= lcd_e_d;
         lcd_rs_q    <= lcd_rs_d;
         lcd_data_q  <= lcd_data_d;
`ifdef LCD_AUTO_LINE_EN
         line_q      <= line_d;
         col_q       <= col_d;
         ins_pend_q  <= ins_pend_d;
         ins_data_q  <= ins_data_d;
`endif
      end
   end

   assign gnt       = gnt_q;
   assign busy      = (state_q != StIdle);
   assign init_done = init_done_q;
   assign lcd_e     = lcd_e_q;
   assign lcd_rs    = lcd_rs_q;
   assign lcd_rw    = 1'b0;
   assign lcd_data  = lcd_data_q;

endmodule

// File: tb/tb_lcd_write_scheduler.sv
// Directed self-checking bench for lcd_write_scheduler at default parameters.
module tb_lcd_write_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req;
   logic [1:0]  req_rs;
   logic [15:0] req_data;
   logic [1:0]  gnt;
   logic        busy;
   logic        init_done;
   logic        lcd_e;
   logic        lcd_rs;
   logic        lcd_rw;
   logic [7:0]  lcd_data;

   int n_tests = 0;
   int n_fail  = 0;
   int dbl_gnt = 0;
   int early_gnt = 0;
   int gnt_cnt = 0;

   always #5 clk = ~clk;

   lcd_write_scheduler u_dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .req_rs   (req_rs),
      .req_data (req_data),
      .gnt      (gnt),
      .busy     (busy),
      .init_done(init_done),
      .lcd_e    (lcd_e),
      .lcd_rs   (lcd_rs),
      .lcd_rw   (lcd_rw),
      .lcd_data (lcd_data)
   );

   always @(negedge clk) begin
      if (gnt == 2'b11) dbl_gnt++;
      if (gnt != 2'b00 && !init_done) early_gnt++;
      if (gnt != 2'b00) gnt_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Waits for lcd_e to rise, captures bus, measures high width in clocks.
   task automatic wait_pulse(input string tag, output logic [7:0] d, output logic rs,
                             output int w);
      int n = 0;
      while (!lcd_e && n < 3000) begin
         step();
         n++;
      end
      check({tag, "_seen"}, lcd_e, 1);
      d = lcd_data;
      rs = lcd_rs;
      w = 0;
      while (lcd_e && w < 100) begin
         step();
         w++;
      end
   endtask

   task automatic wait_gnt(output int n);
      n = 0;
      while (gnt == 2'b00 && n < 3000) begin
         step();
         n++;
      end
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 3000) begin
         step();
         n++;
      end
   endtask

   // Call right after rst is released; first step() is edge 1 of the init run.
   task automatic run_init_check(input string tag);
      logic [7:0] exp_cmd [4];
      logic [7:0] d;
      logic       rs;
      int         n;
      int         w;
      exp_cmd = '{8'h38, 8'h0C, 8'h06, 8'h01};
      n = 0;
      while (!lcd_e && n < 1000) begin
         step();
         n++;
      end
      check({tag, "_first_e_clk"}, n, 355);
      for (int k = 0; k < 4; k++) begin
         wait_pulse({tag, "_init"}, d, rs, w);
         check({tag, "_init_data"}, d, exp_cmd[k]);
         check({tag, "_init_rs"}, rs, 0);
         check({tag, "_init_width"}, w, 5);
      end
      check({tag, "_init_done_early"}, init_done, 0);
      n = 0;
      while (!init_done && n < 2000) begin
         step();
         n++;
      end
      check({tag, "_init_done_delay"}, n, 1000);
   endtask

   initial begin
      logic [7:0] d;
      logic       rs;
      int         n;
      int         w;
      logic [1:0] exp_g [3];
      logic [7:0] exp_d [3];

      rst = 1'b1;
      req = 2'b00;
      req_rs = 2'b00;
      req_data = 16'h0000;
      repeat (3) step();
      check("rst_lcd_e", lcd_e, 0);
      check("rst_lcd_rs", lcd_rs, 0);
      check("rst_lcd_rw", lcd_rw, 0);
      check("rst_lcd_data", lcd_data, 8'h00);
      check("rst_gnt", gnt, 2'b00);
      check("rst_busy", busy, 1);
      check("rst_init_done", init_done, 0);

      // Request pending from before init; must wait for init_done.
      req_rs = 2'b01;
      req_data = 16'h0048;
      req = 2'b01;
      rst = 1'b0;
      run_init_check("boot");
      check("no_gnt_before_init", early_gnt, 0);
      wait_gnt(n);
      check("first_gnt_latency", n, 1);
      check("first_gnt", gnt, 2'b01);
      req = 2'b00;
      step();
      check("gnt_one_clk", gnt, 2'b00);
      wait_pulse("char48", d, rs, w);
      check("char48_data", d, 8'h48);
      check("char48_rs", rs, 1);
      check("char48_width", w, 5);
      wait_idle(n);
      check("char48_hold", n, 10);

      // rr now points at requester 0, so the first tie goes to requester 1.
      exp_g = '{2'b10, 2'b01, 2'b10};
      exp_d = '{8'h42, 8'h41, 8'h42};
      req_rs = 2'b11;
      req_data = 16'h4241;
      req = 2'b11;
      for (int i = 0; i < 3; i++) begin
         wait_gnt(n);
         check("rr_gnt", gnt, exp_g[i]);
         if (i == 2) req = 2'b00;
         wait_pulse("rr", d, rs, w);
         check("rr_data", d, exp_d[i]);
         check("rr_rs", rs, 1);
      end
      wait_idle(n);

      // Clear from requester 1: long hold.
      req_rs = 2'b00;
      req_data = 16'h0100;
      req = 2'b10;
      wait_gnt(n);
      check("clr_gnt", gnt, 2'b10);
      req = 2'b00;
      wait_pulse("clr", d, rs, w);
      check("clr_data", d, 8'h01);
      check("clr_rs", rs, 0);
      wait_idle(n);
      check("clr_hold", n, 1000);

      req_data = 16'hC000;
      req = 2'b10;
      wait_gnt(n);
      check("line2_gnt", gnt, 2'b10);
      req = 2'b00;
      wait_pulse("line2", d, rs, w);
      check("line2_data", d, 8'hC0);
      wait_idle(n);
      check("line2_hold", n, 10);

      // Reset during the enable pulse of a character.
      req_rs = 2'b01;
      req_data = 16'h005A;
      req = 2'b01;
      wait_gnt(n);
      req = 2'b00;
      n = 0;
      while (!lcd_e && n < 100) begin
         step();
         n++;
      end
      check("abort_in_pulse", lcd_e, 1);
      rst = 1'b1;
      step();
      check("abort_lcd_e", lcd_e, 0);
      check("abort_busy", busy, 1);
      check("abort_init_done", init_done, 0);
      check("abort_lcd_data", lcd_data, 8'h00);
      rst = 1'b0;
      run_init_check("replay");

`ifdef LCD_AUTO_LINE_EN
      begin
         int g0;
         g0 = gnt_cnt;
         for (int i = 0; i < 17; i++) begin
            req_rs = 2'b01;
            req_data = 16'(8'h30 + i);
            req = 2'b01;
            wait_gnt(n);
            req = 2'b00;
            if (i == 16) begin
               wait_pulse("wrap_cmd", d, rs, w);
               check("wrap_cmd_data", d, 8'hC0);
               check("wrap_cmd_rs", rs, 0);
            end
            wait_pulse("wrap_char", d, rs, w);
            check("wrap_char_data", d, 32'(8'h30 + i));
            check("wrap_char_rs", rs, 1);
            wait_idle(n);
         end
         step();
         check("wrap_gnt_count", gnt_cnt - g0, 17);
      end
`endif

      check("lcd_rw_zero", lcd_rw, 0);
      check("no_double_gnt", dbl_gnt, 0);
      check("no_early_gnt", early_gnt, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
